// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port ids and
// the one-hot port helper used to build response strobes.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    localparam logic        PORT_CPU = 1'b0;
    localparam logic        PORT_DBG = 1'b1;
    localparam logic [31:0] LED_ADDR = 32'h0000_2000;

    function automatic logic [1:0] port_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Two-way round-robin grant: on contention the port that did not win last
// time is granted; a lone requester always wins. Output is one-hot or zero.
module rr_arbiter2 (
    input  logic [1:0] i_valid,
    input  logic       i_rr_last,
    output logic [1:0] o_grant
);

    // Grant decode from the request pair and the last winner
    always_comb begin
        o_grant = 2'b00;
        case (i_valid)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = i_rr_last ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data_mem port between the CPU (port 0) and debug/DMA
// (port 1): one access in flight, registered memory drive, one-cycle response.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_write,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    input  logic [7:0]          req_sign_mask,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_memwrite,
    output logic                mem_memread,
    output logic [3:0]          mem_sign_mask,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_clk_stall
);

    arb_state_t        r_state;
    logic              r_rr_last;
    logic              r_id;
    logic              r_write;
    logic [3:0]        r_wait_cnt;

    logic [1:0]        w_grant;
    logic              w_grant_id;
    logic              w_accept;
    logic              w_sel_write;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic [3:0]        w_sel_mask;

    rr_arbiter2 u_rr (
        .i_valid   (req_valid),
        .i_rr_last (r_rr_last),
        .o_grant   (w_grant)
    );

    // Ready is offered only while idle and out of reset, straight from the grant
    always_comb begin
        req_ready = 2'b00;
        if (rst_n && (r_state == ST_IDLE)) begin
            req_ready = w_grant;
        end else begin
            req_ready = 2'b00;
        end
    end

    // Select the fields of the granted port
    always_comb begin
        w_grant_id  = w_grant[1] ? PORT_DBG : PORT_CPU;
        w_accept    = |(req_ready & req_valid);
        w_sel_write = req_write[w_grant_id];
        w_sel_addr  = w_grant_id ? req_addr[2*ADDR_W-1:ADDR_W]   : req_addr[ADDR_W-1:0];
        w_sel_wdata = w_grant_id ? req_wdata[2*DATA_W-1:DATA_W]  : req_wdata[DATA_W-1:0];
        w_sel_mask  = w_grant_id ? req_sign_mask[7:4]            : req_sign_mask[3:0];
    end

    // Access sequencer: accept, one-cycle issue, stall tracking, response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_rr_last     <= 1'b1;
            r_id          <= 1'b0;
            r_write       <= 1'b0;
            r_wait_cnt    <= 4'd0;
            rsp_valid     <= 2'b00;
            rsp_rdata     <= {DATA_W{1'b0}};
            rsp_err       <= 1'b0;
            mem_addr      <= {ADDR_W{1'b0}};
            mem_wdata     <= {DATA_W{1'b0}};
            mem_memwrite  <= 1'b0;
            mem_memread   <= 1'b0;
            mem_sign_mask <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_id          <= w_grant_id;
                        r_write       <= w_sel_write;
                        r_rr_last     <= w_grant_id;
                        mem_addr      <= w_sel_addr;
                        mem_wdata     <= w_sel_wdata;
                        mem_sign_mask <= w_sel_mask;
                        mem_memread   <= ~w_sel_write;
                        mem_memwrite  <= w_sel_write;
                        r_state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mem_memread  <= 1'b0;
                    mem_memwrite <= 1'b0;
                    r_wait_cnt   <= 4'd0;
                    if (r_write) begin
                        r_state <= ST_WAIT;
                    end else begin
                        // Read data is captured while memread is still asserted
                        rsp_valid <= port_onehot(r_id);
                        rsp_rdata <= mem_rdata;
                        rsp_err   <= 1'b0;
                        r_state   <= ST_RESP;
                    end
                end
                ST_WAIT: begin
                    if (!mem_clk_stall) begin
                        rsp_valid  <= port_onehot(r_id);
                        rsp_rdata  <= {DATA_W{1'b0}};
                        rsp_err    <= 1'b0;
                        r_wait_cnt <= 4'd0;
                        r_state    <= ST_RESP;
                    end else if (r_wait_cnt == 4'(MAX_WAIT - 1)) begin
                        rsp_valid  <= port_onehot(r_id);
                        rsp_rdata  <= {DATA_W{1'b0}};
                        rsp_err    <= 1'b1;
                        r_wait_cnt <= 4'd0;
                        r_state    <= ST_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                ST_RESP: begin
                    rsp_valid  <= 2'b00;
                    rsp_rdata  <= {DATA_W{1'b0}};
                    rsp_err    <= 1'b0;
                    r_wait_cnt <= 4'd0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a behavioural data_mem model, expected
// responses queued at accept and compared when rsp_valid pulses.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_sign_mask;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_memwrite;
    logic        mem_memread;
    logic [3:0]  mem_sign_mask;
    logic [31:0] mem_rdata;
    logic        mem_clk_stall;

    typedef struct {
        int          port;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   acc_cnt[2] = '{0, 0};
    int   rd_cnt = 0;
    int   wr_cnt = 0;
    logic rr_last = 1'b1;
    logic stall_forever = 1'b0;
    int   stall_extra = 0;
    int   stall_cnt = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_sign_mask (req_sign_mask),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_memwrite  (mem_memwrite),
        .mem_memread   (mem_memread),
        .mem_sign_mask (mem_sign_mask),
        .mem_rdata     (mem_rdata),
        .mem_clk_stall (mem_clk_stall)
    );

    always #5 clk = ~clk;

    // data_mem model: combinational read pattern, stall during the write plus extra cycles
    assign mem_rdata     = mem_memread ? (mem_addr ^ 32'hC0DE_0000) : 32'h0;
    assign mem_clk_stall = stall_forever | mem_memwrite | (stall_cnt != 0);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_memwrite) stall_cnt <= stall_extra;
        else if (stall_cnt != 0) stall_cnt <= stall_cnt - 1;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Monitor on the falling edge: handshake rules, memory drive, responses, accepts
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_valid != 2'b00) chk("ready_only_valid", {62'd0, req_ready & ~req_valid}, 64'd0);
            if (q.size() != 0) begin
                chk("ready_while_busy", {62'd0, req_ready}, 64'd0);
                if (mem_memread || mem_memwrite) begin
                    chk("mem_addr", {32'd0, mem_addr}, {32'd0, q[0].addr});
                    chk("mem_mask", {60'd0, mem_sign_mask}, {60'd0, q[0].mask});
                    chk("mem_write_dir", {63'd0, mem_memwrite}, {63'd0, q[0].wr});
                    if (mem_memwrite) chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, q[0].wdata});
                end
            end
            if (mem_memread) rd_cnt++;
            if (mem_memwrite) wr_cnt++;
            if (rsp_valid != 2'b00) begin
                if (q.size() == 0) begin
                    chk("rsp_unexpected", {62'd0, rsp_valid}, 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rsp_port", {62'd0, rsp_valid}, {62'd0, port_onehot(e.port[0])});
                    chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
                    chk("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
                    chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
                    chk("read_pulse", 64'(rd_cnt), e.wr ? 64'd0 : 64'd1);
                    chk("write_pulse", 64'(wr_cnt), e.wr ? 64'd1 : 64'd0);
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
            if ((req_valid & req_ready) != 2'b00) begin
                exp_t e;
                int   p;
                if (req_valid == 2'b11) p = rr_last ? 0 : 1;
                else p = req_valid[0] ? 0 : 1;
                chk("grant", {62'd0, req_ready}, {62'd0, port_onehot(p[0])});
                e.port  = p;
                e.wr    = req_write[p];
                e.addr  = req_addr[p*32 +: 32];
                e.wdata = req_wdata[p*32 +: 32];
                e.mask  = req_sign_mask[p*4 +: 4];
                e.rdata = e.wr ? 32'h0 : (e.addr ^ 32'hC0DE_0000);
                e.err   = e.wr & stall_forever;
                e.cyc   = cyc + (!e.wr ? 2 : (stall_forever ? 17 : 3 + stall_extra));
                q.push_back(e);
                rr_last = p[0];
                acc_cnt[p]++;
            end
        end
    end

    // Raise a request on one port and hold it until the arbiter accepts it
    task automatic send(input int p, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m, input logic keep);
        int c0;
        c0 = acc_cnt[p];
        req_write[p]            = wr;
        req_addr[p*32 +: 32]    = a;
        req_wdata[p*32 +: 32]   = d;
        req_sign_mask[p*4 +: 4] = m;
        req_valid[p]            = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (acc_cnt[p] != c0) break;
        end
        chk("accepted", {63'd0, acc_cnt[p] != c0}, 64'd1);
        if (!keep) req_valid[p] = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100; k++) begin
            if (q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drained", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        req_valid     = 2'b11;
        req_write     = 2'b00;
        req_addr      = 64'd0;
        req_wdata     = 64'd0;
        req_sign_mask = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {62'd0, req_ready}, 64'd0);
        chk("rst_rsp", {29'd0, rsp_valid, rsp_err, |rsp_rdata}, 64'd0);
        chk("rst_mem", {25'd0, mem_memread, mem_memwrite, mem_sign_mask, |mem_addr, |mem_wdata}, 64'd0);
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single load on the CPU port, then a store on the debug port
        send(0, 1'b0, 32'h0000_0010, 32'h0, 4'b0111, 1'b0);
        wait_idle();
        send(1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'b0010, 1'b0);
        wait_idle();
        stall_extra = 2;
        send(1, 1'b1, 32'h0000_0040, 32'h1234_5678, 4'b0001, 1'b0);
        wait_idle();
        stall_extra = 0;

        // Both ports streaming loads: grants must alternate
        fork
            begin
                for (int i = 0; i < 4; i++) send(0, 1'b0, 32'h100 + 32'(i * 4), 32'h0, 4'b0111, i != 3);
            end
            begin
                for (int i = 0; i < 4; i++) send(1, 1'b0, 32'h200 + 32'(i * 4), 32'h0, 4'b0101, i != 3);
            end
        join
        wait_idle();

        // Watchdog: stall never drops
        stall_forever = 1'b1;
        send(1, 1'b1, 32'h0000_0080, 32'h0BAD_F00D, 4'b0010, 1'b0);
        wait_idle();
        stall_forever = 1'b0;
        send(0, 1'b0, 32'h0000_0044, 32'h0, 4'b0111, 1'b0);
        wait_idle();

        // Reset while waiting on a stalled store
        stall_forever = 1'b1;
        send(1, 1'b1, 32'h0000_0090, 32'hFFFF_0000, 4'b0010, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_mem", {25'd0, mem_memread, mem_memwrite, mem_sign_mask, |mem_addr, |mem_wdata}, 64'd0);
        chk("arst_rsp", {29'd0, rsp_valid, rsp_err, |rsp_rdata}, 64'd0);
        chk("arst_ready", {62'd0, req_ready}, 64'd0);
        q.delete();
        rd_cnt        = 0;
        wr_cnt        = 0;
        rr_last       = 1'b1;
        stall_forever = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        fork
            send(0, 1'b0, 32'h0000_0300, 32'h0, 4'b0111, 1'b0);
            send(1, 1'b0, 32'h0000_0400, 32'h0, 4'b0111, 1'b0);
        join
        wait_idle();

        // Store to the LED address passes straight through
        send(int'(PORT_CPU), 1'b1, LED_ADDR, 32'h0000_00A5, 4'b0010, 1'b0);
        wait_idle();
        chk("dbg_port_id", 64'(PORT_DBG), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
